// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Each transaction runs IDLE -> ACCESS -> DONE, or IDLE -> DONE when the address is out of range.
module dmem_arbiter #(
    parameter int unsigned N     = 32,
    parameter int unsigned M     = 32,
    parameter int unsigned DEPTH = 32
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_reqA,
    input  logic         i_reqB,
    input  logic         i_weA,
    input  logic         i_weB,
    input  logic [M-1:0] i_addA,
    input  logic [M-1:0] i_addB,
    input  logic [N-1:0] i_dataA,
    input  logic [N-1:0] i_dataB,
    output logic         o_ackA,
    output logic         o_ackB,
    output logic         o_errA,
    output logic         o_errB,
    output logic [N-1:0] o_dataA,
    output logic [N-1:0] o_dataB,
    output logic         o_mem_en,
    output logic         o_mem_readEn,
    output logic         o_mem_writeEn,
    output logic [M-1:0] o_mem_add,
    output logic [N-1:0] o_mem_data,
    input  logic [N-1:0] i_mem_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           gnt_b_q, gnt_b_d;
    logic           last_b_q, last_b_d;
    logic           add_zero_q, add_zero_d;
    logic           ack_a_q, ack_a_d, ack_b_q, ack_b_d;
    logic           err_a_q, err_a_d, err_b_q, err_b_d;
    logic [N-1:0]   data_a_q, data_a_d, data_b_q, data_b_d;
    logic           mem_en_q, mem_en_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d;
    logic [M-1:0]   mem_add_q, mem_add_d;
    logic [N-1:0]   mem_data_q, mem_data_d;

    logic           pick_b;
    logic           sel_we;
    logic [M-1:0]   sel_add;
    logic [N-1:0]   sel_data;
    logic           in_range;
    logic [N-1:0]   rd_word;

    // State and registered-output flops; reset aborts any transaction in flight.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            gnt_b_q    <= 1'b0;
            last_b_q   <= 1'b1;
            add_zero_q <= 1'b0;
            ack_a_q    <= 1'b0;
            ack_b_q    <= 1'b0;
            err_a_q    <= 1'b0;
            err_b_q    <= 1'b0;
            data_a_q   <= '0;
            data_b_q   <= '0;
            mem_en_q   <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_add_q  <= '0;
            mem_data_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_b_q    <= gnt_b_d;
            last_b_q   <= last_b_d;
            add_zero_q <= add_zero_d;
            ack_a_q    <= ack_a_d;
            ack_b_q    <= ack_b_d;
            err_a_q    <= err_a_d;
            err_b_q    <= err_b_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
            mem_en_q   <= mem_en_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_add_q  <= mem_add_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Outputs are decoded from the next state so they line up with the state they belong to.
    always_comb begin
        state_d    = state_q;
        gnt_b_d    = gnt_b_q;
        last_b_d   = last_b_q;
        add_zero_d = add_zero_q;
        ack_a_d    = 1'b0;
        ack_b_d    = 1'b0;
        err_a_d    = 1'b0;
        err_b_d    = 1'b0;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        mem_en_d   = 1'b0;
        mem_rd_d   = 1'b0;
        mem_wr_d   = 1'b0;
        mem_add_d  = '0;
        mem_data_d = '0;
        pick_b     = 1'b0;
        sel_we     = 1'b0;
        sel_add    = '0;
        sel_data   = '0;
        in_range   = 1'b0;
        rd_word    = '0;

        unique case (state_q)
            IDLE: begin
                if (i_reqA || i_reqB) begin
                    // On a tie B wins only if A was granted last.
                    pick_b     = i_reqB && (!i_reqA || !last_b_q);
                    sel_we     = pick_b ? i_weB   : i_weA;
                    sel_add    = pick_b ? i_addB  : i_addA;
                    sel_data   = pick_b ? i_dataB : i_dataA;
                    in_range   = 64'(sel_add) < 64'(DEPTH);
                    gnt_b_d    = pick_b;
                    last_b_d   = pick_b;
                    add_zero_d = (sel_add == '0);
                    if (in_range) begin
                        state_d    = ACCESS;
                        mem_en_d   = 1'b1;
                        mem_rd_d   = !sel_we;
                        mem_wr_d   = sel_we;
                        mem_add_d  = sel_add;
                        mem_data_d = sel_data;
                    end else begin
                        state_d = DONE;
                        ack_a_d = !pick_b;
                        ack_b_d = pick_b;
                        err_a_d = !pick_b;
                        err_b_d = pick_b;
                    end
                end
            end
            ACCESS: begin
                state_d = DONE;
                ack_a_d = !gnt_b_q;
                ack_b_d = gnt_b_q;
                // Word 0 reads as zero whatever the memory returns.
                rd_word = add_zero_q ? '0 : i_mem_data;
                if (mem_rd_q) begin
                    if (gnt_b_q) data_b_d = rd_word;
                    else         data_a_d = rd_word;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_ackA        = ack_a_q;
    assign o_ackB        = ack_b_q;
    assign o_errA        = err_a_q;
    assign o_errB        = err_b_q;
    assign o_dataA       = data_a_q;
    assign o_dataB       = data_b_q;
    assign o_mem_en      = mem_en_q;
    assign o_mem_readEn  = mem_rd_q;
    assign o_mem_writeEn = mem_wr_q;
    assign o_mem_add     = mem_add_q;
    assign o_mem_data    = mem_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random request pairs, checked against a
// transaction-level model (round-robin pointer, shadow memory, expected ack/access cycles).
module tb_dmem_arbiter;

    localparam int unsigned N     = 32;
    localparam int unsigned M     = 32;
    localparam int unsigned DEPTH = 32;

    logic         clk;
    logic         rstn;
    logic         reqA, reqB, weA, weB;
    logic [M-1:0] addA, addB;
    logic [N-1:0] wdA, wdB;
    logic         ackA, ackB, errA, errB;
    logic [N-1:0] rdA, rdB;
    logic         mem_en, mem_rd, mem_wr;
    logic [M-1:0] mem_add;
    logic [N-1:0] mem_wdata;
    logic [N-1:0] mem_rdata;

    logic [N-1:0] mem [DEPTH];
    logic [N-1:0] noise;
    logic         mem_clear;

    logic [N-1:0] shadow [DEPTH];
    logic [N-1:0] exp_d [2];
    bit           last_b;
    int           total;
    int           bad;

    dmem_arbiter #(.N(N), .M(M), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_reqA(reqA), .i_reqB(reqB), .i_weA(weA), .i_weB(weB),
        .i_addA(addA), .i_addB(addB), .i_dataA(wdA), .i_dataB(wdB),
        .o_ackA(ackA), .o_ackB(ackB), .o_errA(errA), .o_errB(errB),
        .o_dataA(rdA), .o_dataB(rdB),
        .o_mem_en(mem_en), .o_mem_readEn(mem_rd), .o_mem_writeEn(mem_wr),
        .o_mem_add(mem_add), .o_mem_data(mem_wdata), .i_mem_data(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] init_word(int i);
        return 32'(i) * 32'h9E37_79B1 + 32'h0000_1111;
    endfunction

    // Behavioural single-port memory; returns noise whenever it is not being read.
    always @(posedge clk) begin
        noise <= $urandom;
        if (mem_clear) begin
            for (int i = 0; i < int'(DEPTH); i++) mem[i] <= init_word(i);
        end else if (mem_en && mem_wr && (mem_add < DEPTH)) begin
            mem[mem_add[4:0]] <= mem_wdata;
        end
    end

    always_comb begin
        mem_rdata = noise;
        if (mem_en && mem_rd && (mem_add < DEPTH)) mem_rdata = mem[mem_add[4:0]];
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk1({tag, "_ackA"}, ackA, 1'b0);
        chk1({tag, "_ackB"}, ackB, 1'b0);
        chk1({tag, "_mem_en"}, mem_en, 1'b0);
        chk1({tag, "_mem_rd"}, mem_rd, 1'b0);
        chk1({tag, "_mem_wr"}, mem_wr, 1'b0);
        chk32({tag, "_mem_add"}, mem_add, 32'h0);
        chk32({tag, "_mem_data"}, mem_wdata, 32'h0);
    endtask

    // One request from each active port, issued together while the arbiter is idle.
    // Model: legal = ACCESS at grant+0 then ack; error = ack at grant+0; the loser is granted
    // in the IDLE cycle following the winner's DONE.
    task automatic pair(input bit ra, input bit wa, input logic [31:0] aa, input logic [31:0] da,
                        input bit rb, input bit wb, input logic [31:0] ab, input logic [31:0] db);
        bit          act [2];
        bit          we [2];
        bit          legal [2];
        logic [31:0] ad [2];
        logic [31:0] dt [2];
        int          g [2];
        int          ackc [2];
        int          f, s, last;
        bit          exp_en, exp_rd, exp_wr, exp_ack, obs_ack, obs_err;
        logic [31:0] exp_add, exp_wd, obs_d;

        act[0] = ra; we[0] = wa; ad[0] = aa; dt[0] = da;
        act[1] = rb; we[1] = wb; ad[1] = ab; dt[1] = db;
        for (int p = 0; p < 2; p++) legal[p] = ad[p] < DEPTH;
        f = (rb && (!ra || !last_b)) ? 1 : 0;
        s = 1 - f;
        g[f] = 1;
        ackc[f] = g[f] + (legal[f] ? 1 : 0);
        g[s] = ackc[f] + 2;
        ackc[s] = g[s] + (legal[s] ? 1 : 0);
        last = act[s] ? ackc[s] : ackc[f];
        last_b = act[s] ? (s == 1) : (f == 1);

        reqA = ra; weA = wa; addA = aa; wdA = da;
        reqB = rb; weB = wb; addB = ab; wdB = db;

        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            exp_en = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_add = '0; exp_wd = '0;
            for (int p = 0; p < 2; p++) begin
                if (act[p] && legal[p] && c == g[p]) begin
                    exp_en = 1'b1; exp_rd = !we[p]; exp_wr = we[p];
                    exp_add = ad[p]; exp_wd = dt[p];
                end
            end
            chk1("mem_en", mem_en, exp_en);
            chk1("mem_readEn", mem_rd, exp_rd);
            chk1("mem_writeEn", mem_wr, exp_wr);
            chk32("mem_add", mem_add, exp_add);
            chk32("mem_data", mem_wdata, exp_wd);
            for (int p = 0; p < 2; p++) begin
                exp_ack = act[p] && (c == ackc[p]);
                obs_ack = (p == 1) ? ackB : ackA;
                obs_err = (p == 1) ? errB : errA;
                chk1((p == 1) ? "ackB" : "ackA", obs_ack, exp_ack);
                if (exp_ack) begin
                    chk1((p == 1) ? "errB" : "errA", obs_err, !legal[p]);
                    if (legal[p] && !we[p]) exp_d[p] = (ad[p] == 0) ? 32'h0 : shadow[ad[p][4:0]];
                    if (legal[p] && we[p]) shadow[ad[p][4:0]] = dt[p];
                    if (p == 1) reqB = 1'b0;
                    else        reqA = 1'b0;
                end
                obs_d = (p == 1) ? rdB : rdA;
                chk32((p == 1) ? "dataB" : "dataA", obs_d, exp_d[p]);
            end
        end
        @(negedge clk);
        chk_quiet("idle");
    endtask

    initial begin
        total = 0; bad = 0;
        last_b = 1'b1;
        exp_d[0] = '0; exp_d[1] = '0;
        for (int i = 0; i < int'(DEPTH); i++) shadow[i] = init_word(i);
        rstn = 1'b0; mem_clear = 1'b1;
        reqA = 1'b0; reqB = 1'b0; weA = 1'b0; weB = 1'b0;
        addA = '0; addB = '0; wdA = '0; wdB = '0;
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        chk1("reset_errA", errA, 1'b0);
        chk1("reset_errB", errB, 1'b0);
        chk32("reset_dataA", rdA, 32'h0);
        chk32("reset_dataB", rdB, 32'h0);
        mem_clear = 1'b0;
        rstn = 1'b1;

        // Tie right after reset: A first, then B; a second tie alternates the same way.
        pair(1, 0, 32'd3, 32'h0, 1, 0, 32'd7, 32'h0);
        pair(1, 0, 32'd4, 32'h0, 1, 0, 32'd8, 32'h0);

        // Write then read back through port A.
        pair(1, 1, 32'd5, 32'hDEAD_BEEF, 0, 0, 32'd0, 32'h0);
        pair(1, 0, 32'd5, 32'h0, 0, 0, 32'd0, 32'h0);
        chk32("rd5_dataA", rdA, 32'hDEAD_BEEF);

        // B reads while A holds its value; then B reads out of range.
        pair(0, 0, 32'd0, 32'h0, 1, 0, 32'd9, 32'h0);
        chk32("iso_dataA", rdA, 32'hDEAD_BEEF);
        pair(0, 0, 32'd0, 32'h0, 1, 0, 32'd32, 32'h0);
        pair(0, 1, 32'd0, 32'h0, 1, 1, 32'hFFFF_FFFF, 32'h5555_AAAA);

        // Word 0 writes are issued but read back as zero.
        pair(1, 1, 32'd0, 32'h0000_1234, 0, 0, 32'd0, 32'h0);
        pair(1, 0, 32'd0, 32'h0, 0, 0, 32'd0, 32'h0);
        chk32("rd0_dataA", rdA, 32'h0);

        // Tie where the winner takes a range error.
        pair(1, 0, 32'd40, 32'h0, 1, 1, 32'd31, 32'hCAFE_F00D);
        pair(1, 0, 32'd31, 32'h0, 1, 0, 32'd33, 32'h0);

        // Reset during ACCESS of an A write aborts it; A wins the first tie afterwards.
        reqA = 1'b1; weA = 1'b1; addA = 32'd11; wdA = 32'h0BAD_0BAD;
        @(negedge clk);
        chk1("pre_rst_mem_en", mem_en, 1'b1);
        rstn = 1'b0;
        #1;
        chk_quiet("midrst");
        chk32("midrst_dataA", rdA, 32'h0);
        chk32("midrst_dataB", rdB, 32'h0);
        reqA = 1'b0;
        @(negedge clk);
        chk1("midrst_ackA", ackA, 1'b0);
        exp_d[0] = '0; exp_d[1] = '0;
        last_b = 1'b1;
        rstn = 1'b1;
        pair(1, 0, 32'd11, 32'h0, 1, 0, 32'd5, 32'h0);

        // Random request pairs.
        for (int k = 0; k < 60; k++) begin
            bit          ra, rb, wa, wb;
            logic [31:0] aa, ab, da, db;
            ra = 1'($urandom_range(0, 1));
            rb = ra ? 1'($urandom_range(0, 1)) : 1'b1;
            wa = 1'($urandom_range(0, 1));
            wb = 1'($urandom_range(0, 1));
            aa = 32'($urandom_range(0, DEPTH + 3));
            ab = 32'($urandom_range(0, DEPTH + 3));
            da = $urandom;
            db = $urandom;
            pair(ra, wa, aa, da, rb, wb, ab, db);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
